// File: rtl/div_hilo_ctrl_pkg.sv
// div_hilo_ctrl_pkg: shared state encoding for the divide controller.
`default_nettype none

package div_hilo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/div_hilo_ctrl_hilo_regs.sv
// div_hilo_ctrl_hilo_regs: HI/LO registers with divide-commit priority over WB writes.
// Optional macro HILO_FWD_EN makes the pending write visible on hi/lo in the write cycle.
`default_nettype none

module div_hilo_ctrl_hilo_regs (
  input  logic        clk,
  input  logic        reset,
  input  logic        commit,
  input  logic [31:0] commit_hi,
  input  logic [31:0] commit_lo,
  input  logic        wb_hi_we,
  input  logic        wb_lo_we,
  input  logic [31:0] wb_wdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_next, lo_next;
  logic        hi_we, lo_we;

  // WB holds the older instruction, so the divide commit is the later write and wins.
  always_comb begin
    hi_we   = commit | wb_hi_we;
    lo_we   = commit | wb_lo_we;
    hi_next = commit ? commit_hi : wb_wdata;
    lo_next = commit ? commit_lo : wb_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      if (hi_we) hi_q <= hi_next;
      if (lo_we) lo_q <= lo_next;
    end
  end

`ifdef HILO_FWD_EN
  assign hi = (hi_we && !reset) ? hi_next : hi_q;
  assign lo = (lo_we && !reset) ? lo_next : lo_q;
`else
  assign hi = hi_q;
  assign lo = lo_q;
`endif

endmodule

`default_nettype wire

// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl: EX-stage divide issue/stall FSM, result buffer and HI/LO commit.
// Optional macro HILO_FWD_EN forwards pending HI/LO writes (see div_hilo_ctrl_hilo_regs).
`default_nettype none

module div_hilo_ctrl
  import div_hilo_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_div_req,
  input  logic        ex_div_sign,
  input  logic [31:0] ex_src_a,
  input  logic [31:0] ex_src_b,
  input  logic        ex_hold,
  input  logic        ex_flush,
  output logic        ex_stall,
  output logic        div_en,
  output logic        div_sign,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_cancel,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_finish,
  input  logic        wb_hi_we,
  input  logic        wb_lo_we,
  input  logic [31:0] wb_wdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t      state, state_next;
  logic [31:0] res_q, res_r;
  logic        capture, commit, issue, cancel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      res_q <= 32'd0;
      res_r <= 32'd0;
    end else begin
      state <= state_next;
      if (capture) begin
        res_q <= div_q;
        res_r <= div_r;
      end
    end
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    cancel     = 1'b0;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ex_div_req && !ex_flush) begin
          issue      = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A flush beats a same-cycle finish; that result is dropped.
        if (ex_flush) begin
          cancel     = 1'b1;
          state_next = ST_DRAIN;
        end else if (div_finish) begin
          capture    = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ex_flush) begin
          state_next = ST_IDLE;
        end else if (!ex_hold) begin
          commit     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // The cancelled divide still runs; wait for its stale finish.
        if (div_finish) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign div_en     = issue && !reset;
  assign div_cancel = cancel && !reset;
  assign ex_stall   = ex_div_req && !ex_flush && (state != ST_DONE) && !reset;
  assign div_sign   = ex_div_sign;
  assign div_a      = ex_src_a;
  assign div_b      = ex_src_b;

  div_hilo_ctrl_hilo_regs u_hilo_regs (
    .clk       (clk),
    .reset     (reset),
    .commit    (commit),
    .commit_hi (res_r),
    .commit_lo (res_q),
    .wb_hi_we  (wb_hi_we),
    .wb_lo_we  (wb_lo_we),
    .wb_wdata  (wb_wdata),
    .hi        (hi),
    .lo        (lo)
  );

endmodule

`default_nettype wire

// File: tb/tb_div_hilo_ctrl.sv
// tb_div_hilo_ctrl: scoreboard bench with a behavioural iterative-divider model.
`default_nettype none

module tb_div_hilo_ctrl;

  localparam int LAT = 17;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_div_req, ex_div_sign, ex_hold, ex_flush;
  logic [31:0] ex_src_a, ex_src_b;
  logic        ex_stall, div_en, div_sign, div_cancel, div_finish;
  logic [31:0] div_a, div_b, div_q, div_r;
  logic        wb_hi_we, wb_lo_we;
  logic [31:0] wb_wdata, hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  int n_cancel = 0;
  int n_issue = 0;

  logic [64:0] issue_q[$];  // {sign, a, b}
  logic [63:0] hilo_q[$];   // {hi, lo}
  logic [63:0] hilo_prev = 64'd0;

  always #5 clk = ~clk;

  div_hilo_ctrl dut (
    .clk(clk), .reset(reset),
    .ex_div_req(ex_div_req), .ex_div_sign(ex_div_sign),
    .ex_src_a(ex_src_a), .ex_src_b(ex_src_b),
    .ex_hold(ex_hold), .ex_flush(ex_flush), .ex_stall(ex_stall),
    .div_en(div_en), .div_sign(div_sign), .div_a(div_a), .div_b(div_b),
    .div_cancel(div_cancel), .div_q(div_q), .div_r(div_r), .div_finish(div_finish),
    .wb_hi_we(wb_hi_we), .wb_lo_we(wb_lo_we), .wb_wdata(wb_wdata),
    .hi(hi), .lo(lo)
  );

  // Divider model: ignores cancel and always runs to completion.
  logic       dv_busy;
  int         dv_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dv_busy <= 1'b0;
      dv_cnt  <= 0;
      div_q   <= 32'd0;
      div_r   <= 32'd0;
    end else if (div_en) begin
      dv_busy <= 1'b1;
      dv_cnt  <= LAT - 1;
      if (div_sign) begin
        div_q <= $signed(div_a) / $signed(div_b);
        div_r <= $signed(div_a) % $signed(div_b);
      end else begin
        div_q <= div_a / div_b;
        div_r <= div_a % div_b;
      end
    end else if (dv_busy) begin
      if (dv_cnt == 0) dv_busy <= 1'b0;
      else dv_cnt <= dv_cnt - 1;
    end
  end
  assign div_finish = dv_busy && (dv_cnt == 0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT issues or hi/lo change.
  always @(negedge clk) begin
    if (div_en) begin
      n_issue++;
      if (issue_q.size() == 0) chk("unexpected_div_en", 64'd1, 64'd0);
      else begin
        logic [64:0] e;
        e = issue_q.pop_front();
        chk("issue_sign", {63'd0, div_sign}, {63'd0, e[64]});
        chk("issue_ab", {div_a, div_b}, e[63:0]);
      end
    end
    if (div_cancel) n_cancel++;
    if ({hi, lo} !== hilo_prev) begin
      if (hilo_q.size() == 0) chk("unexpected_hilo_change", {hi, lo}, hilo_prev);
      else chk("hilo", {hi, lo}, hilo_q.pop_front());
      hilo_prev = {hi, lo};
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Runs one divide from request to EX exit. Entered and left just after a posedge.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input int hold_cycles, input logic wb_sim,
                         input int exp_issue, input int exp_stall);
    int cyc, issue_at;
    issue_q.push_back({sgn, a, b});
    hilo_q.push_back({ehi, elo});
    ex_div_req = 1'b1; ex_div_sign = sgn; ex_src_a = a; ex_src_b = b;
    ex_hold = (hold_cycles > 0);
    cyc = 0; issue_at = -1;
    @(negedge clk);
    while (ex_stall && cyc < 200) begin
      if (div_en && issue_at < 0) issue_at = cyc;
      cyc++;
      @(negedge clk);
    end
    chk("issue_cycle", 64'(issue_at), 64'(exp_issue));
    chk("stall_cycles", 64'(cyc), 64'(exp_stall));
    if (hold_cycles > 0) begin
      repeat (hold_cycles - 1) begin
        @(negedge clk);
        chk("stall_in_hold", {63'd0, ex_stall}, 64'd0);
      end
      step();
      ex_hold = 1'b0;
    end
    if (wb_sim) begin
      wb_hi_we = 1'b1; wb_wdata = 32'hAAAA5555;
`ifdef HILO_FWD_EN
      #1 chk("fwd_hi_same_cycle", {32'd0, hi}, {32'd0, ehi});
`endif
    end
    step();
    wb_hi_we = 1'b0;
    ex_div_req = 1'b0;
    if (wb_sim) chk("hi_after_sim_write", {32'd0, hi}, {32'd0, ehi});
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ex_div_req = 1'b1; ex_div_sign = 1'b0; ex_src_a = 32'd5; ex_src_b = 32'd1;
    ex_hold = 1'b0; ex_flush = 1'b0;
    wb_hi_we = 1'b0; wb_lo_we = 1'b0; wb_wdata = 32'd0;
    @(negedge clk);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_outs", {61'd0, ex_stall, div_en, div_cancel}, 64'd0);
    step();
    ex_div_req = 1'b0;
    reset = 1'b0;
    step();

    // Unsigned and signed divides.
    run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 0, 1'b0, 0, LAT + 1);
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 1'b0, 0, LAT + 1);

    // Flush in the fifth BUSY cycle; the new request waits out the stale finish.
    issue_q.push_back({1'b0, 32'd1000, 32'd10});
    ex_div_req = 1'b1; ex_div_sign = 1'b0; ex_src_a = 32'd1000; ex_src_b = 32'd10;
    repeat (5) step();
    ex_flush = 1'b1;
    @(negedge clk);
    chk("cancel_pulse", {62'd0, div_cancel, ex_stall}, 64'd2);
    step();
    ex_flush = 1'b0;
    run_div(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 0, 1'b0, LAT - 5, (LAT - 5) + LAT + 1);

    // Hold for three DONE cycles, then commit once.
    run_div(1'b0, 32'd50, 32'd7, 32'd1, 32'd7, 3, 1'b0, 0, LAT + 1);

    // WB write to HI colliding with a divide commit of R=2.
    run_div(1'b0, 32'd20, 32'd6, 32'd2, 32'd3, 0, 1'b1, 0, LAT + 1);

    // Plain MTLO, then MTHI+MTLO together.
    hilo_q.push_back({32'd2, 32'h12345678});
    wb_lo_we = 1'b1; wb_wdata = 32'h12345678;
    step();
    wb_lo_we = 1'b0;
    step();
    hilo_q.push_back({32'hDEADBEEF, 32'hDEADBEEF});
    wb_hi_we = 1'b1; wb_lo_we = 1'b1; wb_wdata = 32'hDEADBEEF;
    step();
    wb_hi_we = 1'b0; wb_lo_we = 1'b0;
    step();

    // Reset in the middle of BUSY, then a request that issues straight away.
    issue_q.push_back({1'b0, 32'd77, 32'd5});
    ex_div_req = 1'b1; ex_src_a = 32'd77; ex_src_b = 32'd5;
    repeat (4) step();
    hilo_q.push_back(64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy_outs", {61'd0, ex_stall, div_en, div_cancel}, 64'd0);
    chk("rst_mid_busy_hilo", {hi, lo}, 64'd0);
    step();
    reset = 1'b0;
    run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 0, 1'b0, 0, LAT + 1);
    repeat (LAT + 3) step();

    chk("cancel_count", 64'(n_cancel), 64'd1);
    chk("issue_count", 64'(n_issue), 64'd8);
    chk("issue_q_left", 64'(issue_q.size()), 64'd0);
    chk("hilo_q_left", 64'(hilo_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
